adxl345_sample_packer: RTL and testbench
========================================

// Module: adxl345_sample_packer
// PURPOSE
//  Downstream of the ADXL345 driver. Consumes its per-register SPI response
//  stream (DATAX0..DATAZ1, one 16-bit beat per register read) and packs each
//  6-beat frame into one 3-axis signed sample. Optionally box-averages
//  2**AVG_LOG2 frames. Emits one 48-bit {z,y,x} beat per output sample for
//  filtering/telemetry logic.
// PARAMETERS
//  AVG_LOG2     0   log2 of frames averaged per output (0 = passthrough, max 8)
//  DROP_CNT_W   16  width of saturating dropped-frame counter
// PORTS
//  sys_clk          in   1    single clock domain
//  reset            in   1    synchronous, active-high
//  raw_stream       axis sink (DATA_WIDTH=16): tdata[7:0]=register byte,
//                   tdata[15:8] ignored; tlast marks DATAZ1 beat; tvalid/tready
//  sample_stream    axis source (DATA_WIDTH=48): tdata={z[15:0],y[15:0],x[15:0]}
//                   signed; tvalid/tready; tlast tied 1
//  dropped_frames   out  DROP_CNT_W  saturating count of discarded frames
//  sample_count     out  32   output beats accepted downstream, wraps
// BEHAVIOUR
//  Reset: beat_idx=0, state=COLLECT, accumulators=0, frame_cnt=0,
//   sample_stream.tvalid=0, tdata=0, dropped_frames=0, sample_count=0.
//  Beat accept = raw tvalid && tready. Byte order per frame: X0,X1,Y0,Y1,Z0,Z1
//   (low byte first); axis = {hi,lo} as signed 16 (driver uses right-justified,
//   sign-extended format).
//  raw_stream.tready = !(sample_stream.tvalid && !sample_stream.tready).
//  FSM COLLECT: each accept stores byte, beat_idx++.
//   - idx=5 && tlast: frame complete -> add x,y,z into accumulators.
//   - tlast && idx<5: frame dropped, dropped_frames++ (sat), idx=0, stay COLLECT.
//   - idx=5 && !tlast: frame dropped, dropped_frames++, go RESYNC.
//  FSM RESYNC: accept and discard beats; on tlast beat -> idx=0, COLLECT.
//  Accumulators: signed 16+AVG_LOG2 bits each; cleared on reset and on output.
//   frame_cnt counts completed frames mod 2**AVG_LOG2; when it wraps (every
//   frame if AVG_LOG2=0) the sum including the current frame is arithmetic-
//   shifted right by AVG_LOG2 (floor toward -inf), truncated to 16 bits, and
//   loaded into sample_stream.tdata with tvalid=1; accumulators then restart.
//  Latency: tvalid rises the cycle after the DATAZ1 beat is accepted.
//  Output holds tdata stable while tvalid && !tready; tvalid clears on accept
//   unless a new sample loads in that same cycle (then stays 1, new data).
//  sample_count increments on each sample_stream accept.
//  Dropped frames never touch accumulators or frame_cnt.
//  Reset mid-frame discards partial frame and partial average; no output.
// STRUCTURE
//  adxl345_pkg: register address localparams, BYTES_PER_FRAME=6,
//   typedef struct packed {logic signed [15:0] z,y,x;} adxl345_sample_t,
//   typedef enum {PACK_COLLECT, PACK_RESYNC} pack_state_t.
//  Sub-module adxl345_axis_accum (x3): signed accumulate/clear/shift-out per
//   axis, parameterised by AVG_LOG2. FSM, byte regs, output reg in top.
// TESTING
//  1 AVG_LOG2=0: beats 34,12,FF,FF,00,01(tlast) -> one beat x=0x1234,
//    y=-1, z=0x0100, tvalid 1 cycle after last accept; dropped=0.
//  2 AVG_LOG2=2: x frames 1,2,3,-2 -> x=1; next -1,-1,-1,-2 -> x=-2 (floor);
//    no output after frames 1..3 of each group.
//  3 tlast on beat 3 -> no output, dropped=1; following clean frame outputs.
//  4 6 beats no tlast, 2 junk beats, tlast -> dropped=1, RESYNC exited;
//    next clean frame outputs correct values.
//  5 sample tready=0 with two frames queued -> raw tready=0 after first
//    sample, tdata stable; release -> both samples in order, sample_count=2.
//  6 reset after 3 beats -> outputs/counters zero; next 6 beats give
//    correct sample; randomized tvalid/tready gaps yield identical results.

Source files
------------

// File: rtl/adxl345_pkg.sv
// Shared types and constants for the ADXL345 sample packer: register map,
// frame geometry, packed 3-axis sample and packer FSM states.
package adxl345_pkg;

  localparam logic [7:0] REG_DATAX0 = 8'h32;
  localparam logic [7:0] REG_DATAX1 = 8'h33;
  localparam logic [7:0] REG_DATAY0 = 8'h34;
  localparam logic [7:0] REG_DATAY1 = 8'h35;
  localparam logic [7:0] REG_DATAZ0 = 8'h36;
  localparam logic [7:0] REG_DATAZ1 = 8'h37;

  localparam int BYTES_PER_FRAME = 6;

  typedef struct packed {
    logic signed [15:0] z;
    logic signed [15:0] y;
    logic signed [15:0] x;
  } adxl345_sample_t;

  typedef enum logic {
    PACK_COLLECT = 1'b0,
    PACK_RESYNC  = 1'b1
  } pack_state_t;

  // Axis words arrive low byte first; rejoin as a signed 16-bit value.
  function automatic logic signed [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/adxl345_sample_packer_if.sv
// AXI-stream style link used for both the raw register stream and the
// packed sample stream.
interface adxl345_sample_packer_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adxl345_axis_accum.sv
// Per-axis signed accumulator: sums frames, and on flush emits the floor
// average of the running sum plus the current frame, then restarts from zero.
module adxl345_axis_accum #(
  parameter int AVG_LOG2 = 0
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               add_i,
  input  logic               flush_i,
  input  logic signed [15:0] sample_i,
  output logic signed [15:0] avg_o
);

  localparam int ACC_W = 16 + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [ACC_W-1:0] shr_s;

  assign sum_s = acc_q + ACC_W'(sample_i);
  // Arithmetic shift gives floor toward -inf for negative sums.
  assign shr_s = sum_s >>> AVG_LOG2;
  assign avg_o = shr_s[15:0];

  always_comb begin
    acc_d = acc_q;
    if (add_i && flush_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = sum_s;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/adxl345_sample_packer.sv
// Packs 6-beat ADXL345 register frames into {z,y,x} samples, optionally
// box-averaging 2**AVG_LOG2 frames per output beat.
module adxl345_sample_packer
  import adxl345_pkg::*;
#(
  parameter int AVG_LOG2   = 0,
  parameter int DROP_CNT_W = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  adxl345_sample_packer_if.slave  raw_stream,
  adxl345_sample_packer_if.master sample_stream,
  output logic [DROP_CNT_W-1:0]   dropped_frames,
  output logic [31:0]             sample_count
);

  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_FRAME - 1);

  pack_state_t           state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            byte_q [0:4];
  logic [7:0]            byte_d [0:4];
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  out_valid_q, out_valid_d;
  adxl345_sample_t       out_data_q, out_data_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic [31:0]           count_q, count_d;

  logic            raw_ready_s, accept_s, out_accept_s;
  logic            frame_done_s, drop_s, wrap_s;
  adxl345_sample_t cur_s, avg_s;
  logic            unused_hi_s;

  assign unused_hi_s  = ^raw_stream.tdata[15:8];
  assign raw_ready_s  = !(out_valid_q && !sample_stream.tready);
  assign accept_s     = raw_stream.tvalid && raw_ready_s;
  assign out_accept_s = out_valid_q && sample_stream.tready;
  assign frame_done_s = accept_s && (state_q == PACK_COLLECT) && (idx_q == LAST_IDX) && raw_stream.tlast;
  // A frame is bad if tlast comes early or fails to come on the sixth beat.
  assign drop_s       = accept_s && (state_q == PACK_COLLECT) &&
                        (raw_stream.tlast != (idx_q == LAST_IDX));
  assign wrap_s       = (frame_cnt_q == CNT_LAST);

  assign cur_s.x = join_bytes(byte_q[1], byte_q[0]);
  assign cur_s.y = join_bytes(byte_q[3], byte_q[2]);
  assign cur_s.z = join_bytes(raw_stream.tdata[7:0], byte_q[4]);

  adxl345_axis_accum #(.AVG_LOG2(AVG_LOG2)) u_accum_x (
    .sys_clk(sys_clk), .reset(reset), .add_i(frame_done_s), .flush_i(wrap_s),
    .sample_i(cur_s.x), .avg_o(avg_s.x)
  );
  adxl345_axis_accum #(.AVG_LOG2(AVG_LOG2)) u_accum_y (
    .sys_clk(sys_clk), .reset(reset), .add_i(frame_done_s), .flush_i(wrap_s),
    .sample_i(cur_s.y), .avg_o(avg_s.y)
  );
  adxl345_axis_accum #(.AVG_LOG2(AVG_LOG2)) u_accum_z (
    .sys_clk(sys_clk), .reset(reset), .add_i(frame_done_s), .flush_i(wrap_s),
    .sample_i(cur_s.z), .avg_o(avg_s.z)
  );

  assign raw_stream.tready    = raw_ready_s;
  assign sample_stream.tvalid = out_valid_q;
  assign sample_stream.tdata  = out_data_q;
  assign sample_stream.tlast  = 1'b1;
  assign dropped_frames       = drop_q;
  assign sample_count         = count_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    frame_cnt_d = frame_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    drop_d      = drop_q;
    count_d     = count_q;

    if (accept_s) begin
      case (state_q)
        PACK_COLLECT: begin
          if (idx_q != LAST_IDX) begin
            byte_d[idx_q] = raw_stream.tdata[7:0];
          end else begin
            byte_d = byte_q;
          end
          if (raw_stream.tlast) begin
            idx_d = 3'd0;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = 3'd0;
            state_d = PACK_RESYNC;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        PACK_RESYNC: begin
          if (raw_stream.tlast) begin
            idx_d   = 3'd0;
            state_d = PACK_COLLECT;
          end else begin
            idx_d = 3'd0;
          end
        end
        default: begin
          idx_d   = 3'd0;
          state_d = PACK_COLLECT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (drop_s && (drop_q != {DROP_CNT_W{1'b1}})) begin
      drop_d = drop_q + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end

    if (frame_done_s) begin
      frame_cnt_d = wrap_s ? {CNT_W{1'b0}} : frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // A frame only completes while the output is free, so loading never overwrites a held beat.
    if (frame_done_s && wrap_s) begin
      out_valid_d = 1'b1;
      out_data_d  = avg_s;
    end else if (out_accept_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (out_accept_s) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= PACK_COLLECT;
      idx_q       <= 3'd0;
      byte_q      <= '{default: 8'h00};
      frame_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_q      <= '0;
      count_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      frame_cnt_q <= frame_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      drop_q      <= drop_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_adxl345_sample_packer.sv
// Scoreboard bench: a passthrough packer (AVG_LOG2=0) and an averaging
// packer (AVG_LOG2=2) driven with directed frames and hand-computed results.
module tb_adxl345_sample_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adxl345_sample_packer_if #(.DATA_WIDTH(16)) raw0 ();
  adxl345_sample_packer_if #(.DATA_WIDTH(48)) smp0 ();
  adxl345_sample_packer_if #(.DATA_WIDTH(16)) raw2 ();
  adxl345_sample_packer_if #(.DATA_WIDTH(48)) smp2 ();

  logic [15:0] drop0, drop2;
  logic [31:0] cnt0, cnt2;

  adxl345_sample_packer #(.AVG_LOG2(0), .DROP_CNT_W(16)) dut0 (
    .sys_clk(clk), .reset(rst), .raw_stream(raw0), .sample_stream(smp0),
    .dropped_frames(drop0), .sample_count(cnt0)
  );
  adxl345_sample_packer #(.AVG_LOG2(2), .DROP_CNT_W(16)) dut2 (
    .sys_clk(clk), .reset(rst), .raw_stream(raw2), .sample_stream(smp2),
    .dropped_frames(drop2), .sample_count(cnt2)
  );

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q0 [$];
  logic [47:0] exp_q2 [$];
  bit gaps_en = 1'b0;
  bit rand_rdy_en = 1'b0;
  bit b_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] pack(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    return {z, y, x};
  endfunction

  // Scoreboard monitors: pop expected sample on every output handshake.
  always @(negedge clk) begin
    if (!rst && smp0.tvalid && smp0.tready) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample0: got 0x%0h expected none", smp0.tdata);
      end else begin
        check("sample0", {16'h0, smp0.tdata}, {16'h0, exp_q0.pop_front()});
        check("tlast0", {63'h0, smp0.tlast}, 64'h1);
      end
    end
    if (!rst && smp2.tvalid && smp2.tready) begin
      if (exp_q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_sample2: got 0x%0h expected none", smp2.tdata);
      end else begin
        check("sample2", {16'h0, smp2.tdata}, {16'h0, exp_q2.pop_front()});
      end
    end
  end

  // Random backpressure on the passthrough packer's output.
  always @(posedge clk) begin
    #1;
    if (rand_rdy_en) smp0.tready = 1'($urandom_range(0, 1));
  end

  task automatic drive_beat(input bit sel, input logic [7:0] b, input bit last);
    int n;
    logic rdy;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    if (sel) begin raw2.tvalid = 1'b1; raw2.tdata = {8'hA5, b}; raw2.tlast = last; end
    else     begin raw0.tvalid = 1'b1; raw0.tdata = {8'hA5, b}; raw0.tlast = last; end
    n = 0;
    forever begin
      @(negedge clk);
      rdy = sel ? raw2.tready : raw0.tready;
      if (rdy) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL beat_timeout: raw tready stuck at 0 expected 1");
        break;
      end
    end
    @(posedge clk); #1;
    if (sel) begin raw2.tvalid = 1'b0; raw2.tlast = 1'b0; end
    else     begin raw0.tvalid = 1'b0; raw0.tlast = 1'b0; end
  endtask

  task automatic send_frame(input bit sel, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    drive_beat(sel, x[7:0], 1'b0);
    drive_beat(sel, x[15:8], 1'b0);
    drive_beat(sel, y[7:0], 1'b0);
    drive_beat(sel, y[15:8], 1'b0);
    drive_beat(sel, z[7:0], 1'b0);
    drive_beat(sel, z[15:8], 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q0.size() != 0 || exp_q2.size() != 0 || smp0.tvalid || smp2.tvalid) begin
      @(posedge clk); #1;
      n++;
      if (n > 1000) begin
        checks++; errors++;
        $display("FAIL drain_timeout: pending %0d expected 0", exp_q0.size() + exp_q2.size());
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q0.delete();
    exp_q2.delete();
  endtask

  logic [15:0] rx [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] ry [4] = '{16'h1357, 16'h2468, 16'hFF00, 16'h00FF};
  logic [15:0] rz [4] = '{16'hCAFE, 16'h0000, 16'h0123, 16'hFEDC};

  initial begin
    rst = 1'b1;
    raw0.tvalid = 1'b0; raw0.tdata = 16'h0; raw0.tlast = 1'b0;
    raw2.tvalid = 1'b0; raw2.tdata = 16'h0; raw2.tlast = 1'b0;
    smp0.tready = 1'b1; smp2.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_tvalid", {63'h0, smp0.tvalid}, 64'h0);
    check("rst_tdata", {16'h0, smp0.tdata}, 64'h0);
    check("rst_dropped", {48'h0, drop0}, 64'h0);
    check("rst_count", {32'h0, cnt0}, 64'h0);
    check("rst_raw_tready", {63'h0, raw0.tready}, 64'h1);

    // 1: passthrough frame, tvalid the cycle after DATAZ1
    exp_q0.push_back(pack(16'h1234, 16'hFFFF, 16'h0100));
    send_frame(1'b0, 16'h1234, 16'hFFFF, 16'h0100);
    check("t1_latency", {63'h0, smp0.tvalid}, 64'h1);
    drain();
    check("t1_dropped", {48'h0, drop0}, 64'h0);

    // 2: four-frame average with floor rounding
    send_frame(1'b1, 16'h0001, 16'd100, 16'hFFFC);
    check("t2_no_out_f1", {63'h0, smp2.tvalid}, 64'h0);
    send_frame(1'b1, 16'h0002, 16'd100, 16'hFFFC);
    check("t2_no_out_f2", {63'h0, smp2.tvalid}, 64'h0);
    send_frame(1'b1, 16'h0003, 16'd100, 16'hFFFC);
    check("t2_no_out_f3", {63'h0, smp2.tvalid}, 64'h0);
    exp_q2.push_back(pack(16'h0001, 16'h0064, 16'hFFFC));
    send_frame(1'b1, 16'hFFFE, 16'd100, 16'hFFFD);
    send_frame(1'b1, 16'hFFFF, 16'h0000, 16'h0007);
    check("t2_no_out_g2f1", {63'h0, smp2.tvalid}, 64'h0);
    send_frame(1'b1, 16'hFFFF, 16'h0000, 16'h0000);
    check("t2_no_out_g2f2", {63'h0, smp2.tvalid}, 64'h0);
    send_frame(1'b1, 16'hFFFF, 16'h0000, 16'h0000);
    check("t2_no_out_g2f3", {63'h0, smp2.tvalid}, 64'h0);
    exp_q2.push_back(pack(16'hFFFE, 16'h0000, 16'h0001));
    send_frame(1'b1, 16'hFFFE, 16'h0000, 16'h0000);
    drain();

    // 3: short frame
    drive_beat(1'b0, 8'h11, 1'b0);
    drive_beat(1'b0, 8'h22, 1'b0);
    drive_beat(1'b0, 8'h33, 1'b1);
    check("t3_dropped", {48'h0, drop0}, 64'h1);
    check("t3_no_out", {63'h0, smp0.tvalid}, 64'h0);
    exp_q0.push_back(pack(16'h0005, 16'h0006, 16'h0007));
    send_frame(1'b0, 16'h0005, 16'h0006, 16'h0007);
    drain();

    // 4: overlong frame forces resync
    for (int i = 0; i < 6; i++) drive_beat(1'b0, 8'(i + 1), 1'b0);
    drive_beat(1'b0, 8'hEE, 1'b0);
    drive_beat(1'b0, 8'hDD, 1'b0);
    drive_beat(1'b0, 8'hCC, 1'b1);
    check("t4_dropped", {48'h0, drop0}, 64'h2);
    check("t4_no_out", {63'h0, smp0.tvalid}, 64'h0);
    exp_q0.push_back(pack(16'hFED4, 16'h7FFF, 16'h8000));
    send_frame(1'b0, 16'hFED4, 16'h7FFF, 16'h8000);
    drain();

    // 5: output backpressure holds data and stalls the raw side
    do_reset();
    smp0.tready = 1'b0;
    exp_q0.push_back(pack(16'h0001, 16'h0002, 16'h0003));
    send_frame(1'b0, 16'h0001, 16'h0002, 16'h0003);
    check("t5_raw_tready_low", {63'h0, raw0.tready}, 64'h0);
    exp_q0.push_back(pack(16'hFFF0, 16'h0010, 16'h0020));
    b_done = 1'b0;
    fork
      begin
        send_frame(1'b0, 16'hFFF0, 16'h0010, 16'h0020);
        b_done = 1'b1;
      end
    join_none
    repeat (4) @(posedge clk);
    #1;
    check("t5_tdata_held", {16'h0, smp0.tdata}, {16'h0, pack(16'h0001, 16'h0002, 16'h0003)});
    check("t5_tvalid_held", {63'h0, smp0.tvalid}, 64'h1);
    check("t5_b_stalled", {63'h0, b_done}, 64'h0);
    smp0.tready = 1'b1;
    for (int n = 0; n < 300 && !b_done; n++) begin @(posedge clk); #1; end
    check("t5_b_done", {63'h0, b_done}, 64'h1);
    drain();
    check("t5_count", {32'h0, cnt0}, 64'h2);

    // 6: reset mid-frame, then clean and gapped traffic
    do_reset();
    drive_beat(1'b0, 8'h77, 1'b0);
    drive_beat(1'b0, 8'h66, 1'b0);
    drive_beat(1'b0, 8'h55, 1'b0);
    do_reset();
    check("t6_rst_tvalid", {63'h0, smp0.tvalid}, 64'h0);
    check("t6_rst_dropped", {48'h0, drop0}, 64'h0);
    check("t6_rst_count", {32'h0, cnt0}, 64'h0);
    exp_q0.push_back(pack(16'h0ABC, 16'hF00D, 16'h0042));
    send_frame(1'b0, 16'h0ABC, 16'hF00D, 16'h0042);
    drain();
    gaps_en = 1'b1;
    rand_rdy_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q0.push_back(pack(rx[i], ry[i], rz[i]));
      send_frame(1'b0, rx[i], ry[i], rz[i]);
    end
    rand_rdy_en = 1'b0;
    @(posedge clk);
    #2 smp0.tready = 1'b1;
    gaps_en = 1'b0;
    drain();
    check("t6_count", {32'h0, cnt0}, 64'h5);
    check("t6_dropped", {48'h0, drop0}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
